// File: rtl/vdg_address_counter.sv
// vdg_address_counter: video RAM fetch address generator with per-mode row repeat
// and scanlines-per-frame measurement, driven by the VDG timing outputs.
module vdg_address_counter #(
    parameter int ADDR_W = 16,
    parameter int LCNT_W = 10
) (
    input  logic              Clk,
    input  logic              RSTn,
    input  logic              HSn,
    input  logic              FSn,
    input  logic              DA0,
    input  logic [2:0]        VMode,
    input  logic [6:0]        Offset,
    output logic [ADDR_W-1:0] VAddr,
    output logic              Fetch,
    output logic              FrameTick,
    output logic [LCNT_W-1:0] LinesPerFrame
);
    logic              hs_s1_q, hs_s2_q, fs_s1_q, fs_s2_q, da_s1_q, da_s2_q;
    logic              hs_s1_d, hs_s2_d, fs_s1_d, fs_s2_d, da_s1_d, da_s2_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d, row_start_q, row_start_d;
    logic [3:0]        row_line_q, row_line_d, rep_q, rep_d;
    logic [LCNT_W-1:0] hcount_q, hcount_d, lpf_q, lpf_d;
    logic              fetch_q, fetch_d, tick_q, tick_d;
    logic              hs_fall, fs_fall, da_edge;
    assign hs_fall = ~hs_s1_q & hs_s2_q;
    assign fs_fall = ~fs_s1_q & fs_s2_q;
    assign da_edge = da_s1_q ^ da_s2_q;
    always_comb begin
        hs_s1_d     = HSn;
        hs_s2_d     = hs_s1_q;
        fs_s1_d     = FSn;
        fs_s2_d     = fs_s1_q;
        da_s1_d     = DA0;
        da_s2_d     = da_s1_q;
        vaddr_d     = vaddr_q;
        row_start_d = row_start_q;
        row_line_d  = row_line_q;
        rep_d       = rep_q;
        hcount_d    = hcount_q;
        lpf_d       = lpf_q;
        fetch_d     = 1'b0;
        tick_d      = 1'b0;
        if (fs_fall) begin
            vaddr_d     = ADDR_W'({Offset, 9'b0});
            row_start_d = ADDR_W'({Offset, 9'b0});
            row_line_d  = 4'd0;
            rep_d       = (VMode == 3'd0) ? 4'd12 : (VMode <= 3'd2) ? 4'd3 :
                          (VMode <= 3'd4) ? 4'd2 : 4'd1;
            lpf_d       = hcount_q;
            hcount_d    = hs_fall ? LCNT_W'(1) : '0;
            tick_d      = 1'b1;
        end else if (hs_fall) begin
            hcount_d = (&hcount_q) ? hcount_q : hcount_q + LCNT_W'(1);
            // Last repeat of a row: keep the advanced address as the next row's start.
            if (row_line_q == rep_q - 4'd1) begin
                row_line_d  = 4'd0;
                row_start_d = vaddr_q;
            end else begin
                row_line_d = row_line_q + 4'd1;
                vaddr_d    = row_start_q;
            end
        end else if (da_edge) begin
            vaddr_d = vaddr_q + ADDR_W'(1);
            fetch_d = 1'b1;
        end
    end
    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            hs_s1_q     <= 1'b1;
            hs_s2_q     <= 1'b1;
            fs_s1_q     <= 1'b1;
            fs_s2_q     <= 1'b1;
            da_s1_q     <= 1'b0;
            da_s2_q     <= 1'b0;
            vaddr_q     <= '0;
            row_start_q <= '0;
            row_line_q  <= 4'd0;
            rep_q       <= 4'd12;
            hcount_q    <= '0;
            lpf_q       <= '0;
            fetch_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            hs_s1_q     <= hs_s1_d;
            hs_s2_q     <= hs_s2_d;
            fs_s1_q     <= fs_s1_d;
            fs_s2_q     <= fs_s2_d;
            da_s1_q     <= da_s1_d;
            da_s2_q     <= da_s2_d;
            vaddr_q     <= vaddr_d;
            row_start_q <= row_start_d;
            row_line_q  <= row_line_d;
            rep_q       <= rep_d;
            hcount_q    <= hcount_d;
            lpf_q       <= lpf_d;
            fetch_q     <= fetch_d;
            tick_q      <= tick_d;
        end
    end
    assign VAddr         = vaddr_q;
    assign Fetch         = fetch_q;
    assign FrameTick     = tick_q;
    assign LinesPerFrame = lpf_q;
endmodule
